wrr_burst_scheduler: RTL and testbench

Weighted round-robin scheduler that shares one downstream resource port between `request_lines` requesters at transaction (burst) granularity. A granted requester holds the resource from its first beat through its `last` beat. Ownership then stays with that requester for up to its programmed weight of consecutive transactions before priority rotates. It sits in front of the shared datapath in place of a plain per-cycle arbiter, wherever multi-beat transfers must not be interleaved.

---
 rtl/wrr_burst_scheduler_if.sv | 27 ++
 rtl/wrr_burst_scheduler.sv | 125 ++++++++++++
 tb/tb_wrr_burst_scheduler.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/wrr_burst_scheduler_if.sv
// Handshake bundle between requesters, the burst scheduler and the shared resource port.
interface wrr_burst_scheduler_if #(
    parameter int request_lines = 4,
    parameter int weight_w      = 4
);
    localparam int id_w = (request_lines > 1) ? $clog2(request_lines) : 1;

    logic [request_lines-1:0]          req;
    logic [request_lines-1:0]          last;
    logic [request_lines*weight_w-1:0] weight;
    logic                              res_ready;
    logic [request_lines-1:0]          grant;
    logic                              grant_valid;
    logic [id_w-1:0]                   grant_id;
    logic                              beat_fire;
    logic                              abort_err;

    modport slave (
        input  req, last, weight, res_ready,
        output grant, grant_valid, grant_id, beat_fire, abort_err
    );

    modport master (
        output req, last, weight, res_ready,
        input  grant, grant_valid, grant_id, beat_fire, abort_err
    );
endinterface

// File: rtl/wrr_burst_scheduler.sv
// Weighted round-robin arbiter that hands the resource out per burst, holding ownership
// for up to `weight` consecutive transactions before rotating.
module wrr_lane #(
    parameter int weight_w = 4,
    parameter int id_w     = 2,
    parameter int idx      = 0
) (
    input  logic                req,
    input  logic [id_w-1:0]     ptr,
    input  logic [weight_w-1:0] weight,
    output logic                hi_req,
    output logic [weight_w-1:0] w_eff
);
    // Requests at or above ptr win first; the rest cover the wrap-around half of the search.
    assign hi_req = req && (id_w'(idx) >= ptr);
    assign w_eff  = (weight == '0) ? weight_w'(1) : weight;
endmodule

module wrr_burst_scheduler #(
    parameter int request_lines = 4,
    parameter int weight_w      = 4
) (
    input logic                  clk,
    input logic                  rst,
    wrr_burst_scheduler_if.slave bus
);
    localparam int id_w = (request_lines > 1) ? $clog2(request_lines) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OWN  = 1'b1;

    logic [0:0]                              state;
    logic [id_w-1:0]                         ptr;
    logic [id_w-1:0]                         owner;
    logic [weight_w-1:0]                     used;
    logic [request_lines-1:0]                grant;
    logic [id_w-1:0]                         grant_id;
    logic                                    abort_err;

    logic [request_lines-1:0]                hi_req;
    logic [request_lines-1:0][weight_w-1:0]  w_eff;
    logic [id_w-1:0]                         win_hi, win_any, win;
    logic [request_lines-1:0]                win_oh;
    logic                                    cur_req, cur_last, beat_fire, done, rotate;
    logic [weight_w:0]                       u_full;
    logic [id_w-1:0]                         nxt_id;

    for (genvar i = 0; i < request_lines; i++) begin : g_lane
        wrr_lane #(.weight_w(weight_w), .id_w(id_w), .idx(i)) u_lane (
            .req    (bus.req[i]),
            .ptr    (ptr),
            .weight (bus.weight[i*weight_w +: weight_w]),
            .hi_req (hi_req[i]),
            .w_eff  (w_eff[i])
        );
    end

    always_comb begin
        win_hi  = '0;
        win_any = '0;
        for (int i = request_lines - 1; i >= 0; i--) begin
            if (bus.req[i]) win_any = id_w'(i);
            if (hi_req[i])  win_hi  = id_w'(i);
        end
        win    = (|hi_req) ? win_hi : win_any;
        win_oh = request_lines'(1) << win;
    end

    assign cur_req   = bus.req[grant_id];
    assign cur_last  = bus.last[grant_id];
    assign beat_fire = (|grant) & cur_req & bus.res_ready;
    // A dropped request ends the turn exactly like a normal last beat.
    assign done      = (state == OWN) && (!cur_req || (beat_fire && cur_last));
    assign u_full    = {1'b0, used} + 1'b1;
    assign rotate    = u_full >= {1'b0, w_eff[grant_id]};
    assign nxt_id    = (grant_id == id_w'(request_lines - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            grant_id  <= '0;
            ptr       <= '0;
            owner     <= '0;
            used      <= '0;
            abort_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state    <= OWN;
                        grant    <= win_oh;
                        grant_id <= win;
                        if (win != owner) begin
                            used  <= '0;
                            owner <= win;
                        end
                    end
                end
                OWN: begin
                    if (done) begin
                        state    <= IDLE;
                        grant    <= '0;
                        grant_id <= '0;
                        if (!cur_req) abort_err <= 1'b1;
                        if (rotate) begin
                            ptr  <= nxt_id;
                            used <= '0;
                        end else begin
                            // u_full < w_eff here, so the count cannot wrap.
                            ptr  <= grant_id;
                            used <= u_full[weight_w-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant       = grant;
    assign bus.grant_valid = |grant;
    assign bus.grant_id    = grant_id;
    assign bus.beat_fire   = beat_fire;
    assign bus.abort_err   = abort_err;
endmodule

// File: tb/tb_wrr_burst_scheduler.sv
// Directed bench for wrr_burst_scheduler: transaction-level model checked every cycle plus literal pins.
module tb_wrr_burst_scheduler;
    localparam int N  = 4;
    localparam int WW = 4;

    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    wrr_burst_scheduler_if #(.request_lines(N), .weight_w(WW)) bus ();
    wrr_burst_scheduler #(.request_lines(N), .weight_w(WW)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit busy;
        int gid;
        int ptr;
        int owner;
        int used;
        bit ab;
    } ms_t;

    ms_t m;

    // One clock of the scheduler described at transaction level.
    function automatic ms_t step(ms_t s, logic [N-1:0] r, logic [N-1:0] l,
                                 logic [N*WW-1:0] wt, logic rdy);
        ms_t n = s;
        int  w;
        if (!s.busy) begin
            for (int k = 0; k < N; k++) begin
                int idx = (s.ptr + k) % N;
                if (r[idx]) begin
                    n.busy = 1'b1;
                    n.gid  = idx;
                    if (idx != s.owner) begin
                        n.used  = 0;
                        n.owner = idx;
                    end
                    break;
                end
            end
        end else if (!r[s.gid] || (l[s.gid] && rdy)) begin
            if (!r[s.gid]) n.ab = 1'b1;
            w = int'(wt[s.gid*WW +: WW]);
            if (w == 0) w = 1;
            if (s.used + 1 >= w) begin
                n.ptr  = (s.gid + 1) % N;
                n.used = 0;
            end else begin
                n.ptr  = s.gid;
                n.used = s.used + 1;
            end
            n.busy = 1'b0;
            n.gid  = 0;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '{default: 0};
        else     m <= step(m, bus.req, bus.last, bus.weight, bus.res_ready);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_grant", 32'(bus.grant), m.busy ? (32'd1 << m.gid) : 32'd0);
        chk("m_grant_valid", 32'(bus.grant_valid), 32'(m.busy));
        chk("m_grant_id", 32'(bus.grant_id), m.busy ? 32'(m.gid) : 32'd0);
        chk("m_beat_fire", 32'(bus.beat_fire),
            32'(m.busy && bus.req[m.gid] && bus.res_ready));
        chk("m_abort_err", 32'(bus.abort_err), 32'(m.ab));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic rdy);
        bus.req       = r;
        bus.last      = l;
        bus.res_ready = rdy;
    endtask

    task automatic do_reset();
        drive('0, '0, 1'b1);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [3:0] rot_exp [0:8] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                  4'b0000, 4'b1000, 4'b0000, 4'b0001};
    int         wrr_exp [0:9] = '{0, 0, 0, 1, 2, 3, 3, 0, 0, 0};

    initial begin
        rst        = 1'b1;
        bus.weight = 16'h1111;
        drive('0, '0, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_grant_valid", 32'(bus.grant_valid), 32'd0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        chk("rst_abort_err", 32'(bus.abort_err), 32'd0);

        // Strict rotation with all weights 1.
        drive(4'b1111, 4'b1111, 1'b1);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("rot_grant", 32'(bus.grant), 32'(rot_exp[i]));
            if (i % 2 == 0) chk("rot_id", 32'(bus.grant_id), 32'((i / 2) % 4));
        end

        // Weights {3,0,0,2}.
        do_reset();
        bus.weight = 16'h2003;
        drive(4'b1111, 4'b1111, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("wrr_id", 32'(bus.grant_id), 32'(wrr_exp[i]));
            chk("wrr_valid", 32'(bus.grant_valid), 32'd1);
            tick();
            chk("wrr_bubble", 32'(bus.grant_valid), 32'd0);
        end

        // 4-beat burst on req0 with one stall, req1 waiting.
        do_reset();
        bus.weight = 16'h1111;
        drive(4'b0011, 4'b0000, 1'b1);
        tick();
        chk("burst_c1", 32'(bus.grant), 32'b0001);
        tick();
        chk("burst_c2", 32'(bus.grant), 32'b0001);
        bus.res_ready = 1'b0;
        #1 chk("burst_stall_fire", 32'(bus.beat_fire), 32'd0);
        tick();
        chk("burst_c3", 32'(bus.grant), 32'b0001);
        bus.res_ready = 1'b1;
        tick();
        chk("burst_c4", 32'(bus.grant), 32'b0001);
        tick();
        chk("burst_c5", 32'(bus.grant), 32'b0001);
        bus.last = 4'b0001;
        tick();
        chk("burst_bubble", 32'(bus.grant), 32'b0000);
        bus.last = 4'b0000;
        tick();
        chk("burst_next", 32'(bus.grant), 32'b0010);

        // Wrap from ptr=3 to req1, then ptr must be 2.
        do_reset();
        drive(4'b0100, 4'b0100, 1'b1);
        tick();
        chk("wrap_pre", 32'(bus.grant), 32'b0100);
        tick();
        chk("wrap_pre_idle", 32'(bus.grant), 32'b0000);
        drive(4'b0010, 4'b0010, 1'b1);
        tick();
        chk("wrap_grant", 32'(bus.grant), 32'b0010);
        chk("wrap_id", 32'(bus.grant_id), 32'd1);
        drive(4'b1111, 4'b1111, 1'b1);
        tick();
        chk("wrap_idle", 32'(bus.grant), 32'b0000);
        tick();
        chk("wrap_ptr2", 32'(bus.grant), 32'b0100);

        // req2 drops mid-burst.
        do_reset();
        drive(4'b0100, 4'b0000, 1'b1);
        tick();
        chk("abort_own", 32'(bus.grant), 32'b0100);
        tick();
        drive(4'b1000, 4'b0000, 1'b1);
        tick();
        chk("abort_grant", 32'(bus.grant), 32'b0000);
        chk("abort_flag", 32'(bus.abort_err), 32'd1);
        tick();
        chk("abort_rotate", 32'(bus.grant), 32'b1000);
        bus.last = 4'b1000;
        tick();
        tick();
        chk("abort_sticky", 32'(bus.abort_err), 32'd1);
        do_reset();
        chk("abort_cleared", 32'(bus.abort_err), 32'd0);

        // Asynchronous reset while req2 owns the port.
        drive(4'b0100, 4'b0000, 1'b1);
        tick();
        chk("rmid_own", 32'(bus.grant), 32'b0100);
        rst = 1'b1;
        #1 chk("rmid_async", 32'(bus.grant), 32'd0);
        drive(4'b0101, 4'b0101, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        chk("rmid_first", 32'(bus.grant), 32'b0001);

        // Mixed traffic, checked by the model only.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) bus.weight = 16'($urandom);
            bus.req       = 4'($urandom);
            bus.last      = 4'($urandom);
            bus.res_ready = 1'($urandom);
            tick();
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
